// File: rtl/reg_file_ref_pkg.sv
// Shared sizing for the reference-tagged register file (reg_file_ref).
package reg_file_ref_pkg;

    localparam int REG_NUM      = 32;  // architectural registers, $0 hardwired zero
    localparam int ROB_ADDR_BUS = 4;   // ROB tag width
    localparam int REF_CNT_W    = 6;   // holds 0..31 outstanding references
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;

endpackage

// File: rtl/reg_file_ref_read_port.sv
// One combinational read port: zero / tag / value mux, with optional commit bypass.
// Optional feature: REG_FILE_COMMIT_BYPASS_EN forwards a matching same-cycle commit.
module reg_file_ref_read_port
    import reg_file_ref_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_BUS
) (
    input  logic                      en,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      ref_bit,
    input  logic [ROB_ADDR_WIDTH-1:0] tag,
    input  logic [DATA_W-1:0]         value,
    input  logic                      commit_en,
    input  logic [ADDR_W-1:0]         commit_addr,
    input  logic [ROB_ADDR_WIDTH-1:0] commit_tag,
    input  logic [DATA_W-1:0]         commit_data,
    output logic                      is_ref,
    output logic [DATA_W-1:0]         data
);

    logic bypass;

`ifdef REG_FILE_COMMIT_BYPASS_EN
    // The retiring producer's value is already on the commit bus, so skip the tag.
    assign bypass = commit_en && (commit_addr == addr) && ref_bit && (tag == commit_tag);
`else
    assign bypass = 1'b0;
    logic unused_commit;
    assign unused_commit = ^{commit_en, commit_addr, commit_tag, commit_data};
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        is_ref = 1'b0;
        data   = '0;
        if (en && addr != '0) begin
            if (bypass) begin
                data = commit_data;
            end else if (ref_bit) begin
                is_ref = 1'b1;
                data   = {{(DATA_W-ROB_ADDR_WIDTH){1'b0}}, tag};
            end else begin
                data = value;
            end
        end
    end

endmodule

// File: rtl/reg_file_ref.sv
// Architectural register file returning either the committed value or the in-flight ROB tag.
// Optional feature: REG_FILE_COMMIT_BYPASS_EN (read ports forward a matching same-cycle commit).
module reg_file_ref
    import reg_file_ref_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_BUS,
    parameter int REG_COUNT      = REG_NUM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_en_1,
    input  logic [ADDR_W-1:0]         read_addr_1,
    input  logic                      read_en_2,
    input  logic [ADDR_W-1:0]         read_addr_2,
    output logic                      read_is_ref_1,
    output logic [DATA_W-1:0]         read_data_1,
    output logic                      read_is_ref_2,
    output logic [DATA_W-1:0]         read_data_2,
    input  logic                      rename_en,
    input  logic [ADDR_W-1:0]         rename_addr,
    input  logic [ROB_ADDR_WIDTH-1:0] rename_tag,
    input  logic                      commit_en,
    input  logic [ADDR_W-1:0]         commit_addr,
    input  logic [DATA_W-1:0]         commit_data,
    input  logic [ROB_ADDR_WIDTH-1:0] commit_tag,
    input  logic                      flush,
    output logic [REF_CNT_W-1:0]      ref_count
);

    logic [DATA_W-1:0]         values [REG_COUNT];
    logic [ROB_ADDR_WIDTH-1:0] tags   [REG_COUNT];
    logic [REG_COUNT-1:0]      refs;
    logic [REG_COUNT-1:0]      refs_next;
    logic [REF_CNT_W-1:0]      count_next;

    logic rename_hit;
    logic commit_wr;
    logic commit_hit;

    assign rename_hit = rename_en && (rename_addr != '0) && !flush;
    assign commit_wr  = commit_en && (commit_addr != '0);
    // Only the producer named by the stored tag may release the reference.
    assign commit_hit = commit_wr && refs[commit_addr] && (tags[commit_addr] == commit_tag);

    // Priority: commit clear < rename set < flush.
    always_comb begin
        refs_next = refs;
        if (commit_hit) refs_next[commit_addr] = 1'b0;
        if (rename_hit) refs_next[rename_addr] = 1'b1;
        if (flush)      refs_next = '0;
        count_next = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            count_next = count_next + REF_CNT_W'(refs_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refs      <= '0;
            ref_count <= '0;
            // NOTE: the architectural state must read as zero after reset, so the arrays are reset too.
            for (int i = 0; i < REG_COUNT; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
        end else begin
            refs      <= refs_next;
            ref_count <= count_next;
            if (commit_wr)  values[commit_addr] <= commit_data;
            if (rename_hit) tags[rename_addr]   <= rename_tag;
        end
    end

    reg_file_ref_read_port #(.ROB_ADDR_WIDTH(ROB_ADDR_WIDTH)) u_read_1 (
        .en          (read_en_1 && rst),
        .addr        (read_addr_1),
        .ref_bit     (refs[read_addr_1]),
        .tag         (tags[read_addr_1]),
        .value       (values[read_addr_1]),
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .is_ref      (read_is_ref_1),
        .data        (read_data_1)
    );

    reg_file_ref_read_port #(.ROB_ADDR_WIDTH(ROB_ADDR_WIDTH)) u_read_2 (
        .en          (read_en_2 && rst),
        .addr        (read_addr_2),
        .ref_bit     (refs[read_addr_2]),
        .tag         (tags[read_addr_2]),
        .value       (values[read_addr_2]),
        .commit_en   (commit_en),
        .commit_addr (commit_addr),
        .commit_tag  (commit_tag),
        .commit_data (commit_data),
        .is_ref      (read_is_ref_2),
        .data        (read_data_2)
    );

endmodule

// File: doc/reg_file_ref.md
Name: reg_file_ref

Overview:
- Architectural register file with per-register reference tags, for the out-of-order core's ID stage.
- Feeds the operand generator directly upstream through reg_read_is_ref_1/2 and reg_read_data_1/2.
- For each register it returns either the committed value, or the ROB tag of the in-flight producer, with the is_ref flag set.
- ID marks destinations as renamed, ROB commit writes values back, and a flush drops all outstanding references.

Parameters:
- ROB_ADDR_WIDTH, 4, width of a ROB tag; a tag is returned zero-extended in the 32-bit data field.
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- read_en_1  in  1  read port 1 enable.
- read_addr_1  in  5  read port 1 address.
- read_en_2  in  1  read port 2 enable.
- read_addr_2  in  5  read port 2 address.
- read_is_ref_1  out  1  port 1 returns a tag, not a value.
- read_data_1  out  32  port 1 value or zero-extended tag.
- read_is_ref_2  out  1  port 2 returns a tag, not a value.
- read_data_2  out  32  port 2 value or zero-extended tag.
- rename_en  in  1  ID allocates a destination.
- rename_addr  in  5  destination register.
- rename_tag  in  ROB_ADDR_WIDTH  allocated ROB entry.
- commit_en  in  1  ROB retires a register write.
- commit_addr  in  5  retired destination.
- commit_data  in  32  retired value.
- commit_tag  in  ROB_ADDR_WIDTH  ROB entry being retired.
- flush  in  1  pipeline flush (exception or mispredict).
- ref_count  out  6  number of registers with an outstanding reference.

Behaviour:
- Reset (rst=0, asynchronous):
  - All values, ref bits and tags clear to 0; ref_count=0.
  - While rst=0, both read ports output is_ref=0, data=0.
- Read path is combinational from state:
  - Read disabled, or addr=0: is_ref=0, data=0.
  - Ref bit set: is_ref=1, data={zeros, tag}.
  - Otherwise: is_ref=0, data=value.
- Reads see pre-edge state. A read in the same cycle as a rename of the same register returns the old mapping, so "addu $1,$1,$2" reads its own old source.
- Rename (rising edge, rename_en=1, addr≠0): ref bit set, tag=rename_tag. The value is kept.
- rename_addr=0 is ignored.
- Commit (rising edge, commit_en=1, addr≠0):
  - The value is always written with commit_data.
  - The ref bit clears only if the bit is set and the stored tag equals commit_tag. A younger rename keeps its reference.
- Commit and rename in the same cycle:
  - Same address: the value is written, and the ref is set to rename_tag. Rename wins.
  - Different addresses: both take effect independently.
- Flush (rising edge): all ref bits clear.
  - Flush has priority over rename; a same-cycle rename is dropped.
  - A same-cycle commit still writes its value.
- ref_count tracks the number of set ref bits and updates on the same edge as the state.
  - Re-renaming an already-referenced register leaves the count unchanged.
  - Simultaneous set and clear on different registers gives a net change of 0.
  - Flush sets the count to 0.
  - Maximum is 31, since register 0 can never hold a reference.
- No stall output; ROB capacity is managed by the ROB.

Optional Feature:
- Macro: REG_FILE_COMMIT_BYPASS_EN.
- Defined: a read port bypasses the commit path when all of these hold in the same cycle:
  - commit_en=1;
  - commit_addr equals the read address, and the address is non-zero;
  - the register's ref bit is set and its tag equals commit_tag.
  - In that case the port outputs is_ref=0, data=commit_data.
  - The bypass applies even when a same-cycle rename targets that register, since the read still sees pre-edge state.
- Undefined: the read returns the tag until the next cycle, and the ROB must keep the entry readable for one extra cycle.

Decomposition:
- Shared package/header, alongside bus.v:
  - REG_COUNT;
  - ROB tag width macro (ROB_ADDR_BUS);
  - ref_count width.
- One natural sub-module, reg_file_ref_read_port: the combinational read mux with optional bypass, instantiated twice.

Test Plan:
- Reset: hold rst=0, read addr 5 and 0 -> both ports is_ref=0, data=0, ref_count=0.
- Rename then read:
  - rename $3 with tag 7 -> next cycle read $3 gives is_ref=1, data=0x00000007, ref_count=1.
  - Same-cycle read of $3 during the rename gives the old value.
- Matching commit: with $3 referencing tag 7, commit $3=0xDEADBEEF tag 7 -> next cycle is_ref=0, data=0xDEADBEEF, ref_count=0.
  - Bypass build: the same cycle already shows the value.
- Stale commit: rename $4 tag 2, then $4 tag 9, then commit $4 tag 2 -> $4 stays is_ref=1, data=9, ref_count=1.
- Same-address collision: same cycle rename $6 tag 5 and commit $6=0x11 tag 3 -> $6 is_ref=1, tag 5; after flush $6 reads 0x11.
- Flush and register 0:
  - Rename $1, $2, $31, then flush together with rename $8 -> ref_count=0, no register referenced.
  - rename/commit to $0 -> reads 0, ref_count unchanged.
